barker_frame_gen: RTL

//   Upstream source for the Barker-11 correlator. Builds frames of an 11-bit Barker preamble plus

---
 rtl/barker_frame_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/barker_frame_gen.sv
// rtl/barker_frame_gen.sv - Barker-11 preamble + payload frame serialiser, 1-bit stream out
module barker_frame_gen #(
    parameter logic [10:0] BARKER_SEQ    = 11'b11100010010,
    parameter int          PAYLOAD_BYTES = 4,
    parameter int          GAP_CYCLES    = 2
) (
    input  logic        clk25,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic        m_tready,
    output logic        o_busy,
    output logic        o_underrun,
    output logic [15:0] o_frame_cnt
);
    typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

    localparam bit         NO_PAYLOAD = (PAYLOAD_BYTES == 0);
    localparam logic [7:0] LAST_BYTE  = NO_PAYLOAD ? 8'd0 : 8'(PAYLOAD_BYTES - 1);
    localparam logic [7:0] LAST_GAP   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state, nxt_state;
    logic [3:0] bit_idx, nxt_bit_idx;
    logic [7:0] byte_idx, nxt_byte_idx;
    logic [7:0] gap_cnt, nxt_gap_cnt;
    logic [7:0] hold, shreg, nxt_shreg;
    logic       hold_full;
    logic       nxt_tdata, nxt_tvalid, nxt_tlast, nxt_tuser;
    logic       need_byte, frame_done, restart, move, starve;
    logic       start, accept, xfer;

    assign start  = i_en & (hold_full | NO_PAYLOAD);
    assign accept = s_tvalid & s_tready;
    assign xfer   = m_tvalid & m_tready;

    always_ff @(posedge clk25) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_bit_idx  = bit_idx;
        nxt_byte_idx = byte_idx;
        nxt_gap_cnt  = gap_cnt;
        nxt_shreg    = shreg;
        nxt_tdata    = m_tdata;
        nxt_tvalid   = m_tvalid;
        nxt_tlast    = m_tlast;
        nxt_tuser    = m_tuser;
        need_byte    = 1'b0;
        frame_done   = 1'b0;
        restart      = 1'b0;
        move         = 1'b0;
        starve       = 1'b0;

        unique case (state)
            IDLE: restart = 1'b1;
            PRE: begin
                if (xfer) begin
                    if (bit_idx != 4'd0) begin
                        nxt_bit_idx = bit_idx - 4'd1;
                        nxt_tdata   = BARKER_SEQ[nxt_bit_idx];
                        nxt_tlast   = NO_PAYLOAD && (bit_idx == 4'd1);
                    end else if (NO_PAYLOAD) begin
                        frame_done = 1'b1;
                    end else begin
                        nxt_byte_idx = 8'd0;
                        need_byte    = 1'b1;
                    end
                end
            end
            PAY: begin
                // m_tvalid low in PAY only while starved for the next byte
                if (!m_tvalid) begin
                    need_byte = 1'b1;
                end else if (xfer) begin
                    if (bit_idx != 4'd0) begin
                        nxt_bit_idx = bit_idx - 4'd1;
                        nxt_tdata   = shreg[nxt_bit_idx[2:0]];
                        nxt_tlast   = (byte_idx == LAST_BYTE) && (bit_idx == 4'd1);
                    end else if (byte_idx == LAST_BYTE) begin
                        frame_done = 1'b1;
                    end else begin
                        nxt_byte_idx = byte_idx + 8'd1;
                        need_byte    = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    restart = 1'b1;
                end else begin
                    nxt_gap_cnt = gap_cnt + 8'd1;
                end
            end
        endcase

        if (need_byte) begin
            nxt_state = PAY;
            nxt_tlast = 1'b0;
            nxt_tuser = 1'b0;
            if (hold_full) begin
                move        = 1'b1;
                nxt_shreg   = hold;
                nxt_bit_idx = 4'd7;
                nxt_tdata   = hold[7];
                nxt_tvalid  = 1'b1;
            end else begin
                starve     = 1'b1;
                nxt_tdata  = 1'b0;
                nxt_tvalid = 1'b0;
            end
        end

        if (frame_done) begin
            if (GAP_CYCLES != 0) begin
                nxt_state   = GAP;
                nxt_gap_cnt = 8'd0;
                nxt_tdata   = 1'b0;
                nxt_tvalid  = 1'b0;
                nxt_tlast   = 1'b0;
                nxt_tuser   = 1'b0;
            end else begin
                restart = 1'b1;
            end
        end

        if (restart) begin
            if (start) begin
                nxt_state   = PRE;
                nxt_bit_idx = 4'd10;
                nxt_tdata   = BARKER_SEQ[10];
                nxt_tvalid  = 1'b1;
                nxt_tlast   = 1'b0;
                nxt_tuser   = 1'b1;
            end else begin
                nxt_state  = IDLE;
                nxt_tdata  = 1'b0;
                nxt_tvalid = 1'b0;
                nxt_tlast  = 1'b0;
                nxt_tuser  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!i_rst_n) begin
            bit_idx     <= 4'd0;
            byte_idx    <= 8'd0;
            gap_cnt     <= 8'd0;
            shreg       <= 8'd0;
            hold        <= 8'd0;
            hold_full   <= 1'b0;
            m_tdata     <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tuser     <= 1'b0;
            o_underrun  <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            bit_idx  <= nxt_bit_idx;
            byte_idx <= nxt_byte_idx;
            gap_cnt  <= nxt_gap_cnt;
            shreg    <= nxt_shreg;
            m_tdata  <= nxt_tdata;
            m_tvalid <= nxt_tvalid;
            m_tlast  <= nxt_tlast;
            m_tuser  <= nxt_tuser;
            // a same-cycle accept wins over the move so the fresh byte stays held
            if (move) begin
                hold_full <= 1'b0;
            end
            if (accept) begin
                hold      <= s_tdata;
                hold_full <= 1'b1;
            end
            if (starve) begin
                o_underrun <= 1'b1;
            end
            if (frame_done) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        o_busy   = (state != IDLE);
        s_tready = i_rst_n & ~hold_full;
    end
endmodule
